alu_rr_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares the single 8-bit combinational alu (operands a/b, 4-bit select, outputs out/carry/flag) among NREQ requesters. It accepts one operation at a time through a valid/ready handshake and drives the alu from registered operands. It captures the result and returns it on a single response channel, tagged with the requester id, with backpressure. It sits between client blocks and the alu instance, which is instantiated outside this block.

---
 rtl/alu_rr_arbiter.sv | 172 +++++++++++++++++
 tb/tb_alu_rr_arbiter.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_rr_arbiter.sv
// Round-robin front end for a shared combinational ALU: grants one requester at a time,
// drives the ALU from registered operands and returns a tagged, backpressured response.
module alu_rr_arbiter #(
  parameter int  NREQ    = 4,
  parameter int  W       = 8,
  parameter int  MAX_SEL = 8,
  localparam int IDW     = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  input  logic [NREQ*4-1:0] req_sel,
  output logic [W-1:0]      alu_a,
  output logic [W-1:0]      alu_b,
  output logic [3:0]        alu_sel,
  input  logic [W-1:0]      alu_out,
  input  logic              alu_carry,
  input  logic              alu_flag,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [W-1:0]      rsp_out,
  output logic              rsp_carry,
  output logic              rsp_flag,
  output logic              rsp_err,
  output logic              busy,
  output logic [15:0]       op_count,
  output logic [7:0]        err_count
);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

  state_t         state_q, state_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [W-1:0]   a_q, a_d, b_q, b_d;
  logic [3:0]     sel_q, sel_d;
  logic [IDW-1:0] id_q, id_d;
  logic           rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0] rsp_id_q, rsp_id_d;
  logic [W-1:0]   rsp_out_q, rsp_out_d;
  logic           rsp_carry_q, rsp_carry_d;
  logic           rsp_flag_q, rsp_flag_d;
  logic           rsp_err_q, rsp_err_d;
  logic [15:0]    op_count_q, op_count_d;
  logic [7:0]     err_count_q, err_count_d;

  logic           grant_vld;
  logic [IDW-1:0] grant_idx;

  // Scan downward so the index closest to the pointer (smallest offset) is the last writer.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req_valid[(int'(ptr_q) + k) % NREQ]) begin
        grant_vld = 1'b1;
        grant_idx = IDW'((int'(ptr_q) + k) % NREQ);
      end
    end
  end

  always_comb begin
    // NOTE: every signal gets its hold value first so no path leaves it unassigned (no latches).
    state_d     = state_q;
    ptr_d       = ptr_q;
    a_d         = a_q;
    b_d         = b_q;
    sel_d       = sel_q;
    id_d        = id_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_out_d   = rsp_out_q;
    rsp_carry_d = rsp_carry_q;
    rsp_flag_d  = rsp_flag_q;
    rsp_err_d   = rsp_err_q;
    op_count_d  = op_count_q;
    err_count_d = err_count_q;
    req_ready   = '0;

    case (state_q)
      S_IDLE: begin
        if (grant_vld) begin
          req_ready[grant_idx] = ~rst;
          a_d     = req_a[grant_idx*W +: W];
          b_d     = req_b[grant_idx*W +: W];
          sel_d   = req_sel[grant_idx*4 +: 4];
          id_d    = grant_idx;
          ptr_d   = IDW'((int'(grant_idx) + 1) % NREQ);
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (int'(sel_q) <= MAX_SEL) begin
          rsp_out_d   = alu_out;
          rsp_carry_d = alu_carry;
          rsp_flag_d  = alu_flag;
          rsp_err_d   = 1'b0;
        end else begin
          rsp_out_d   = '0;
          rsp_carry_d = 1'b0;
          rsp_flag_d  = 1'b0;
          rsp_err_d   = 1'b1;
          if (err_count_q != 8'hFF) err_count_d = err_count_q + 8'd1;
        end
        rsp_valid_d = 1'b1;
        rsp_id_d    = id_q;
        state_d     = S_RESP;
      end
      S_RESP: begin
        // Payload registers are left alone so they keep their value after rsp_valid drops.
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          if (op_count_q != 16'hFFFF) op_count_d = op_count_q + 16'd1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      sel_q       <= '0;
      id_q        <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_out_q   <= '0;
      rsp_carry_q <= 1'b0;
      rsp_flag_q  <= 1'b0;
      rsp_err_q   <= 1'b0;
      op_count_q  <= '0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sel_q       <= sel_d;
      id_q        <= id_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_out_q   <= rsp_out_d;
      rsp_carry_q <= rsp_carry_d;
      rsp_flag_q  <= rsp_flag_d;
      rsp_err_q   <= rsp_err_d;
      op_count_q  <= op_count_d;
      err_count_q <= err_count_d;
    end
  end

  assign alu_a     = a_q;
  assign alu_b     = b_q;
  assign alu_sel   = sel_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_out   = rsp_out_q;
  assign rsp_carry = rsp_carry_q;
  assign rsp_flag  = rsp_flag_q;
  assign rsp_err   = rsp_err_q;
  assign busy      = (state_q != S_IDLE);
  assign op_count  = op_count_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Bench for alu_rr_arbiter: directed vector table, round-robin/backpressure/reset sequences,
// then randomized traffic against a queue-based reference model; the ALU itself is modelled here.
module tb_alu_rr_arbiter;

  localparam int NREQ    = 4;
  localparam int W       = 8;
  localparam int MAX_SEL = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid, req_ready;
  logic [31:0] req_a, req_b;
  logic [15:0] req_sel;
  logic [7:0]  alu_a, alu_b, alu_out;
  logic [3:0]  alu_sel;
  logic        alu_carry, alu_flag;
  logic        rsp_valid, rsp_ready;
  logic [1:0]  rsp_id;
  logic [7:0]  rsp_out;
  logic        rsp_carry, rsp_flag, rsp_err, busy;
  logic [15:0] op_count;
  logic [7:0]  err_count;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  alu_rr_arbiter #(.NREQ(NREQ), .W(W), .MAX_SEL(MAX_SEL)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_sel(req_sel),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .alu_out(alu_out), .alu_carry(alu_carry), .alu_flag(alu_flag),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_out(rsp_out), .rsp_carry(rsp_carry), .rsp_flag(rsp_flag), .rsp_err(rsp_err),
    .busy(busy), .op_count(op_count), .err_count(err_count)
  );

  // Behavioural ALU: add, sub (carry = borrow), and, or, xor, not a, shl, shr, inc a.
  typedef struct packed {logic [7:0] out; logic carry; logic flag;} alu_res_t;

  function automatic alu_res_t alu_ref(input logic [7:0] a, input logic [7:0] b, input logic [3:0] sel);
    logic [8:0] t;
    alu_res_t   r;
    case (sel)
      4'd0:    t = {1'b0, a} + {1'b0, b};
      4'd1:    t = {1'b0, a} - {1'b0, b};
      4'd2:    t = {1'b0, a & b};
      4'd3:    t = {1'b0, a | b};
      4'd4:    t = {1'b0, a ^ b};
      4'd5:    t = {1'b0, ~a};
      4'd6:    t = {a, 1'b0};
      4'd7:    t = {a[0], 1'b0, a[7:1]};
      4'd8:    t = {1'b0, a} + 9'd1;
      default: t = 9'd0;
    endcase
    r.out   = t[7:0];
    r.carry = t[8];
    r.flag  = (t[7:0] == 8'd0);
    return r;
  endfunction

  alu_res_t alu_res;
  always_comb alu_res = alu_ref(alu_a, alu_b, alu_sel);
  assign alu_out   = alu_res.out;
  assign alu_carry = alu_res.carry;
  assign alu_flag  = alu_res.flag;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_req(input int id, input logic [7:0] a, input logic [7:0] b, input logic [3:0] sel);
    req_a[id*8 +: 8]   = a;
    req_b[id*8 +: 8]   = b;
    req_sel[id*4 +: 4] = sel;
  endtask

  task automatic check_zero(input string name);
    check({name, "_rsp"}, 32'({rsp_valid, rsp_id, rsp_out, rsp_carry, rsp_flag, rsp_err, busy}), 32'd0);
    check({name, "_alu"}, 32'({req_ready, alu_a, alu_b, alu_sel}), 32'd0);
    check({name, "_cnt"}, 32'({op_count, err_count}), 32'd0);
  endtask

  typedef struct packed {
    logic [1:0] id;
    logic [7:0] a, b;
    logic [3:0] sel;
    logic [7:0] out;
    logic       carry, flag, err;
  } vec_t;

  vec_t vecs [13];
  int   exp_ops, exp_errs;

  // One full operation from an IDLE negedge; returns at the next IDLE negedge.
  task automatic do_row(input vec_t v);
    req_valid       = '0;
    req_valid[v.id] = 1'b1;
    set_req(int'(v.id), v.a, v.b, v.sel);
    rsp_ready = 1'b1;
    #1;
    check("row_ready", 32'(req_ready), 32'(4'b1 << v.id));
    @(negedge clk);
    req_valid = '0;
    #1;
    check("row_exec", 32'({busy, rsp_valid, req_ready, alu_a, alu_b, alu_sel}),
          32'({1'b1, 1'b0, 4'b0, v.a, v.b, v.sel}));
    @(negedge clk);
    if (v.err) exp_errs++;
    check("row_rsp", 32'({rsp_valid, rsp_id, rsp_out, rsp_carry, rsp_flag, rsp_err}),
          32'({1'b1, v.id, v.out, v.carry, v.flag, v.err}));
    check("row_err_count", 32'(err_count), 32'(exp_errs));
    @(negedge clk);
    exp_ops++;
    check("row_done", 32'({rsp_valid, busy, op_count}), 32'({1'b0, 1'b0, 16'(exp_ops)}));
  endtask

  // Randomized-phase reference model: pointer, outstanding-op flag and expected-response queue.
  typedef struct packed {logic [1:0] id; logic [7:0] out; logic carry, flag, err;} exp_rsp_t;
  exp_rsp_t   exp_q[$];
  int         m_ptr, m_age, m_ops, m_errs;
  bit         m_busy;
  logic [3:0] just_acc;

  task automatic rnd_cycle(input bit drain);
    logic [3:0] exp_rdy;
    logic [3:0] s;
    int         g;
    bit         hs;
    exp_rsp_t   e;
    alu_res_t   r;
    @(negedge clk);
    rsp_ready = drain ? 1'b1 : ($urandom_range(0, 3) != 0);
    for (int i = 0; i < NREQ; i++) begin
      if (drain) req_valid[i] = 1'b0;
      else if (!req_valid[i] || just_acc[i]) begin
        req_valid[i] = 1'($urandom_range(0, 1));
        set_req(i, 8'($urandom), 8'($urandom), 4'($urandom_range(0, 10)));
      end
    end
    just_acc = '0;
    #1;
    exp_rdy = '0;
    g = -1;
    if (!m_busy)
      for (int k = 0; k < NREQ; k++)
        if (g < 0 && req_valid[(m_ptr + k) % NREQ]) g = (m_ptr + k) % NREQ;
    if (g >= 0) exp_rdy[g] = 1'b1;
    check("rnd_ready", 32'(req_ready), 32'(exp_rdy));
    check("rnd_rsp_valid", 32'(rsp_valid), 32'(m_busy && m_age >= 1));
    hs = m_busy && (m_age >= 1) && rsp_ready;
    if (g >= 0) begin
      s     = req_sel[g*4 +: 4];
      e.id  = 2'(g);
      e.err = (int'(s) > MAX_SEL);
      r     = alu_ref(req_a[g*8 +: 8], req_b[g*8 +: 8], s);
      e.out   = e.err ? 8'd0 : r.out;
      e.carry = e.err ? 1'b0 : r.carry;
      e.flag  = e.err ? 1'b0 : r.flag;
      exp_q.push_back(e);
      if (e.err) m_errs++;
      m_ptr = (g + 1) % NREQ;
      m_busy = 1'b1;
      m_age = 0;
      just_acc[g] = 1'b1;
    end else if (hs) begin
      e = exp_q.pop_front();
      check("rnd_rsp", 32'({rsp_id, rsp_out, rsp_carry, rsp_flag, rsp_err}),
            32'({e.id, e.out, e.carry, e.flag, e.err}));
      m_ops++;
      m_busy = 1'b0;
    end else if (m_busy) m_age++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int order [11] = '{0, 1, 2, 3, 0, 1, 2, 3, 1, 3, 1};
    int n;

    vecs[0]  = '{2'd2, 8'd10,  8'd5,   4'd0, 8'd15,  1'b0, 1'b0, 1'b0};
    vecs[1]  = '{2'd0, 8'd10,  8'd5,   4'd0, 8'd15,  1'b0, 1'b0, 1'b0};
    vecs[2]  = '{2'd0, 8'd10,  8'd5,   4'd1, 8'd5,   1'b0, 1'b0, 1'b0};
    vecs[3]  = '{2'd0, 8'd10,  8'd5,   4'd2, 8'd0,   1'b0, 1'b1, 1'b0};
    vecs[4]  = '{2'd0, 8'd10,  8'd5,   4'd3, 8'd15,  1'b0, 1'b0, 1'b0};
    vecs[5]  = '{2'd0, 8'd10,  8'd5,   4'd4, 8'd15,  1'b0, 1'b0, 1'b0};
    vecs[6]  = '{2'd0, 8'd10,  8'd5,   4'd5, 8'hF5,  1'b0, 1'b0, 1'b0};
    vecs[7]  = '{2'd0, 8'd10,  8'd5,   4'd6, 8'h14,  1'b0, 1'b0, 1'b0};
    vecs[8]  = '{2'd0, 8'd10,  8'd5,   4'd7, 8'h05,  1'b0, 1'b0, 1'b0};
    vecs[9]  = '{2'd0, 8'd10,  8'd5,   4'd8, 8'd11,  1'b0, 1'b0, 1'b0};
    vecs[10] = '{2'd0, 8'd200, 8'd100, 4'd0, 8'd44,  1'b1, 1'b0, 1'b0};
    vecs[11] = '{2'd1, 8'd10,  8'd5,   4'd9, 8'd0,   1'b0, 1'b0, 1'b1};
    vecs[12] = '{2'd3, 8'd5,   8'd10,  4'd1, 8'hFB,  1'b1, 1'b0, 1'b0};

    // Reset with random requests present.
    rst       = 1'b1;
    req_valid = 4'($urandom_range(1, 15));
    req_a     = $urandom;
    req_b     = $urandom;
    req_sel   = 16'($urandom);
    rsp_ready = 1'($urandom_range(0, 1));
    repeat (2) @(negedge clk);
    #1;
    check_zero("in_reset");
    @(negedge clk);
    rst       = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b1;
    #1;
    check_zero("post_reset");
    @(negedge clk);
    check_zero("first_idle");

    exp_ops  = 0;
    exp_errs = 0;
    for (int i = 0; i < 13; i++) do_row(vecs[i]);

    // Round-robin with all four requesting, then only ids 1 and 3.
    for (int i = 0; i < NREQ; i++) set_req(i, 8'(16 * i), 8'd1, 4'd0);
    req_valid = 4'hF;
    rsp_ready = 1'b1;
    for (int k = 0; k < 11; k++) begin
      if (k == 8) req_valid = 4'b1010;
      #1;
      n = 0;
      while (req_ready == 4'b0 && n < 6) begin
        @(negedge clk);
        #1;
        n++;
      end
      check("rr_grant", 32'(req_ready), 32'(4'b1 << order[k]));
      @(negedge clk);
      n = 0;
      while (!rsp_valid && n < 6) begin
        @(negedge clk);
        n++;
      end
      check("rr_rsp", 32'({rsp_valid, rsp_id, rsp_out}),
            32'({1'b1, 2'(order[k]), 8'(16 * order[k] + 1)}));
      if (k == 10) req_valid = '0;
      @(negedge clk);
    end

    // Backpressure: response held for 5 cycles while id 1 waits.
    rsp_ready = 1'b0;
    set_req(0, 8'h33, 8'h11, 4'd0);
    req_valid = 4'b0011;
    #1;
    check("bp_grant", 32'(req_ready), 32'(4'b0001));
    repeat (2) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      check("bp_hold", 32'({rsp_valid, rsp_id, rsp_out, rsp_err, busy, req_ready}),
            32'({1'b1, 2'd0, 8'h44, 1'b0, 1'b1, 4'b0}));
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    #1;
    check("bp_release", 32'({rsp_valid, busy, req_ready, rsp_out}), 32'({1'b0, 1'b0, 4'b0010, 8'h44}));
    req_valid = '0;
    @(negedge clk);

    // Reset during EXEC of an id 3 operation.
    set_req(3, 8'd7, 8'd7, 4'd0);
    req_valid = 4'b1000;
    @(negedge clk);
    req_valid = '0;
    #1;
    check("mid_exec_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    check("mid_rst", 32'({rsp_valid, busy, op_count, err_count}), 32'd0);
    check("mid_rst_alu", 32'({alu_a, alu_b, alu_sel}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    set_req(2, 8'd1, 8'd2, 4'd0);
    req_valid = 4'b1100;
    #1;
    check("post_rst_grant", 32'(req_ready), 32'(4'b0100));
    @(negedge clk);
    req_valid = '0;
    n = 0;
    while (!rsp_valid && n < 6) begin
      @(negedge clk);
      n++;
    end
    check("post_rst_rsp", 32'({rsp_valid, rsp_id, rsp_out}), 32'({1'b1, 2'd2, 8'd3}));
    @(negedge clk);
    check("post_rst_count", 32'({op_count, err_count}), 32'({16'd1, 8'd0}));

    // Randomized traffic against the reference model from a fresh reset.
    rst = 1'b1;
    @(negedge clk);
    rst       = 1'b0;
    req_valid = '0;
    m_ptr = 0; m_age = 0; m_ops = 0; m_errs = 0; m_busy = 1'b0;
    just_acc = '0;
    exp_q.delete();
    repeat (400) rnd_cycle(1'b0);
    repeat (12) rnd_cycle(1'b1);
    check("rnd_final", 32'({busy, op_count, err_count}), 32'({1'b0, 16'(m_ops), 8'(m_errs)}));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
